// File: rtl/sensor_ranging.sv
// Periodic ultrasonic ranging controller: fires the sensor core, converts echo
// width to millimetres and keeps a moving average over 2^AVG_LOG2 samples.
module sensor_ranging #(
    parameter int unsigned PERIOD_CYC  = 3000000,
    parameter int unsigned TIMEOUT_CYC = 1500000,
    parameter int unsigned MM_MUL      = 225,
    parameter int unsigned MM_SHIFT    = 16,
    parameter int unsigned MAX_MM      = 4000,
    parameter int unsigned AVG_LOG2    = 2
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        enable,
    output logic        fire_measure,
    input  logic        done_measure,
    input  logic [31:0] data_measure,
    output logic [15:0] dist_mm,
    output logic [15:0] dist_avg_mm,
    output logic        dist_vld,
    output logic        timeout_err,
    output logic [7:0]  err_cnt
);

    localparam int unsigned PW    = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int unsigned TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SW    = 16 + AVG_LOG2;

    typedef enum logic [2:0] {IDLE, FIRE, WAIT, CONV, UPD, TOUT} state_t;

    state_t                   state, state_nx;
    logic [PW-1:0]            period_cnt;
    logic                     tick;
    logic [TW-1:0]            wait_cnt;
    logic [31:0]              echo_cnt;
    logic [47:0]              prod, mm_full;
    logic [15:0]              mm_clamp, mm;
    logic [DEPTH-1:0][15:0]   win, win_nx;
    logic [SW-1:0]            sum, sum_nx;
    logic                     win_full;

    assign tick = (period_cnt == PW'(PERIOD_CYC - 1));

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)      period_cnt <= '0;
        else if (!enable || tick) period_cnt <= '0;
        else             period_cnt <= period_cnt + PW'(1);
    end

    // Dropping enable aborts from any state; a done in the same cycle is lost.
    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (tick) state_nx = FIRE;
                FIRE:    state_nx = WAIT;
                WAIT: begin
                    if (done_measure)                          state_nx = CONV;
                    else if (wait_cnt == TW'(TIMEOUT_CYC - 1)) state_nx = TOUT;
                end
                CONV:    state_nx = UPD;
                UPD:     state_nx = IDLE;
                TOUT:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    assign prod     = {16'd0, echo_cnt} * 48'(MM_MUL);
    assign mm_full  = prod >> MM_SHIFT;
    assign mm_clamp = (mm_full > 48'(MAX_MM)) ? 16'(MAX_MM) : mm_full[15:0];

    // Window index 0 holds the newest sample, DEPTH-1 the oldest.
    always_comb begin
        win_nx = win;
        sum_nx = sum;
        if (!win_full) begin
            for (int i = 0; i < DEPTH; i++) win_nx[i] = mm;
            sum_nx = SW'(mm) << AVG_LOG2;
        end else begin
            win_nx = {win[DEPTH-2:0], mm};
            sum_nx = sum - SW'(win[DEPTH-1]) + SW'(mm);
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            fire_measure <= 1'b0;
            dist_vld     <= 1'b0;
            wait_cnt     <= '0;
            echo_cnt     <= '0;
            mm           <= '0;
            win          <= '0;
            sum          <= '0;
            win_full     <= 1'b0;
            dist_mm      <= '0;
            dist_avg_mm  <= '0;
            timeout_err  <= 1'b0;
            err_cnt      <= '0;
        end else begin
            fire_measure <= (state_nx == FIRE);
            dist_vld     <= 1'b0;
            if (state == FIRE)      wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + TW'(1);
            if (enable && state == WAIT && done_measure) echo_cnt <= data_measure;
            if (state == CONV) mm <= mm_clamp;

            if (!enable) begin
                win_full <= 1'b0;
            end else if (state == UPD) begin
                win         <= win_nx;
                sum         <= sum_nx;
                win_full    <= 1'b1;
                dist_mm     <= mm;
                dist_avg_mm <= sum_nx[SW-1:AVG_LOG2];
                dist_vld    <= 1'b1;
                timeout_err <= 1'b0;
            end else if (state == TOUT) begin
                timeout_err <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/sensor_ranging.md
Name: sensor_ranging

Overview:
- Measurement controller directly downstream of the ultrasonic sensor core.
- Periodically issues a one-cycle fire_measure pulse and waits for done_measure or a timeout.
- Converts the raw echo-width count (clk_sys cycles) to millimetres and keeps a 2^AVG_LOG2-sample moving average.
- Presents results with a one-cycle valid strobe to the register/display logic.

Parameters:
PERIOD_CYC, 3000000, fire period in clk_sys cycles (60 ms @ 50 MHz)
TIMEOUT_CYC, 1500000, max cycles in WAIT before declaring no echo
MM_MUL, 225, conversion multiplier (mm = cnt*MM_MUL >> MM_SHIFT; 0.003433 mm/cycle @ 50 MHz)
MM_SHIFT, 16, conversion right shift
MAX_MM, 4000, clamp ceiling for converted distance
AVG_LOG2, 2, log2 of averaging window depth (1..4)

Ports:
clk_sys  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  run periodic measurement when high
fire_measure  output  1  start pulse to sensor core, one cycle
done_measure  input  1  one-cycle pulse from sensor core, echo falling edge
data_measure  input  32  echo width in clk_sys cycles, stable when done_measure high
dist_mm  output  16  latest converted, clamped distance
dist_avg_mm  output  16  moving average of last 2^AVG_LOG2 distances
dist_vld  output  1  one-cycle strobe: dist_mm/dist_avg_mm updated
timeout_err  output  1  high after a timeout until next successful sample
err_cnt  output  8  saturating timeout counter

Behaviour:
- Reset: all outputs 0, FSM IDLE, period_cnt 0, window marked empty.
- Period counter:
  - Counts 0..PERIOD_CYC-1 while enable is high, wraps at the top.
  - tick is asserted when period_cnt == PERIOD_CYC-1.
  - Cleared to 0 while enable is low.
- FSM states: IDLE, FIRE, WAIT, CONV, UPD, TOUT.
- IDLE: tick & enable -> FIRE. Ticks in any other state are dropped (no queuing).
- FIRE: fire_measure high this cycle only (registered). Next state WAIT; wait_cnt cleared.
- WAIT:
  - wait_cnt increments each cycle.
  - done_measure -> latch data_measure, go to CONV.
  - Else wait_cnt == TIMEOUT_CYC-1 -> TOUT.
  - done_measure wins over a simultaneous timeout.
- CONV:
  - prod = latched * MM_MUL, 48-bit unsigned; mm = prod >> MM_SHIFT.
  - If mm > MAX_MM, mm = MAX_MM. Registered as 16 bits. Next state UPD.
- UPD:
  - If the window is empty, preload every entry with mm and set sum = mm << AVG_LOG2.
  - Else sum = sum - oldest + mm, and mm is shifted into the window.
  - dist_avg_mm = sum >> AVG_LOG2 (truncate); dist_mm = mm; timeout_err cleared; window marked full.
  - Next state IDLE.
- dist_vld timing: high for exactly one cycle, 3 cycles after the cycle in which done_measure is sampled high (D+3), coincident with the new output values.
- TOUT:
  - timeout_err set; err_cnt += 1, saturating at 255.
  - dist_mm, dist_avg_mm and window unchanged; no dist_vld. Next state IDLE.
- done_measure outside WAIT is ignored.
- enable low, any state:
  - FSM -> IDLE next cycle; no fire_measure is issued.
  - An in-flight measurement is discarded, with no dist_vld.
  - Window marked empty.
  - dist_mm, dist_avg_mm, timeout_err and err_cnt are held.
  - Abort wins over a simultaneous done_measure.
- First fire after enable rises: PERIOD_CYC cycles later.
- Integration constraint: TIMEOUT_CYC + 4 < PERIOD_CYC, guaranteeing no dropped ticks in steady state.
- Async reset mid-operation returns everything to reset values immediately.

Test Plan:
(Bench parameters: PERIOD_CYC=1000, TIMEOUT_CYC=600, defaults otherwise.)
- Fire cadence: enable=1 at t0, done_measure never returns -> fire_measure one-cycle pulses at t0+1000, t0+2000, ...; timeout_err=1 and err_cnt=1 after the first 600-cycle WAIT.
- Basic conversion: done_measure with data 291545 at D -> dist_vld at D+3, dist_mm=1000, dist_avg_mm=1000 (preload), timeout_err cleared.
- Averaging: next sample data 582543 -> dist_mm=2000, dist_avg_mm=(1000*3+2000)/4=1250.
- Clamp: data 0x00FFFFFF -> dist_mm=4000. Data 0 -> dist_mm=0.
- Simultaneous events:
  - done_measure in the cycle wait_cnt==599 -> valid sample, no timeout.
  - done_measure outside WAIT -> ignored.
  - 300 timeouts -> err_cnt saturates at 255.
- Abort/reset:
  - enable dropped during WAIT then done_measure -> no dist_vld, outputs held; after re-enable, first sample preloads the window.
  - rst_n low mid-WAIT -> all outputs 0.
